// File: rtl/dilation_stream.sv
// Streaming 3x3 outer-boundary filter: marks background pixels adjacent to foreground
// with the brightest foreground neighbour, using two internal line buffers.
module dilation_stream #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int THRESH = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic       out_last
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [7:0]    TH     = 8'(THRESH);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // Interior rule: a strictly-background centre touching strict foreground takes max(N).
    function automatic logic [7:0] edge_val(input logic [7:0] c, input logic [7:0][7:0] n);
        logic [7:0] mx;
        logic       hit;
        mx  = 8'd0;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (n[i] > mx) begin
                mx = n[i];
            end else begin
                mx = mx;
            end
            hit = hit | (n[i] > TH);
        end
        return (c < TH && hit) ? mx : 8'd0;
    endfunction

    logic [1:0]    state_r;
    logic [XW-1:0] in_x_r, out_x_r;
    logic [YW-1:0] in_y_r, out_y_r;
    logic [7:0]    lb0_r [WIDTH];
    logic [7:0]    lb1_r [WIDTH];
    logic [7:0]    t0_r, t1_r, m0_r, m1_r, b0_r, b1_r;

    logic          advance_s, in_ready_s, load_s, accept_s;
    logic [7:0]    lb0_rd_s, lb1_rd_s, result_s;
    logic          border_s, last_s;

    assign advance_s = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready_s;
    assign in_ready  = in_ready_s;
    assign lb0_rd_s  = lb0_r[in_x_r];
    assign lb1_rd_s  = lb1_r[in_x_r];
    assign border_s  = (out_x_r == {XW{1'b0}}) || (out_x_r == X_LAST) ||
                       (out_y_r == {YW{1'b0}}) || (out_y_r == Y_LAST);
    assign last_s    = (out_x_r == X_LAST) && (out_y_r == Y_LAST);

    // Handshake decode per state.
    always_comb begin
        in_ready_s = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            S_FILL: begin
                in_ready_s = 1'b1;
                load_s     = 1'b0;
            end
            S_RUN: begin
                in_ready_s = advance_s;
                load_s     = in_valid && advance_s;
            end
            S_FLUSH: begin
                in_ready_s = 1'b0;
                load_s     = advance_s;
            end
            default: begin
                in_ready_s = 1'b0;
                load_s     = 1'b0;
            end
        endcase
    end

    // Window columns: col0 = k-2, col1 = k-1 (centre column), current column read live.
    always_comb begin
        result_s = 8'd0;
        if (border_s) begin
            result_s = 8'd0;
        end else begin
            result_s = edge_val(m1_r, {t0_r, t1_r, lb1_rd_s, m0_r, lb0_rd_s, b0_r, b1_r, in_pixel});
        end
    end

    // Line buffers and window shift; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r[in_x_r] <= in_pixel;
            lb1_r[in_x_r] <= lb0_rd_s;
            t0_r <= t1_r;
            t1_r <= lb1_rd_s;
            m0_r <= m1_r;
            m1_r <= lb0_rd_s;
            b0_r <= b1_r;
            b1_r <= in_pixel;
        end
    end

    // State, counters and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FILL;
            in_x_r    <= {XW{1'b0}};
            in_y_r    <= {YW{1'b0}};
            out_x_r   <= {XW{1'b0}};
            out_y_r   <= {YW{1'b0}};
            out_valid <= 1'b0;
            out_pixel <= 8'd0;
            out_last  <= 1'b0;
        end else begin
            if (accept_s) begin
                if (in_x_r == X_LAST) begin
                    in_x_r <= {XW{1'b0}};
                    in_y_r <= (in_y_r == Y_LAST) ? {YW{1'b0}} : in_y_r + YW'(1);
                end else begin
                    in_x_r <= in_x_r + XW'(1);
                end
            end
            if (load_s) begin
                out_valid <= 1'b1;
                out_pixel <= result_s;
                out_last  <= last_s;
                if (out_x_r == X_LAST) begin
                    out_x_r <= {XW{1'b0}};
                    out_y_r <= (out_y_r == Y_LAST) ? {YW{1'b0}} : out_y_r + YW'(1);
                end else begin
                    out_x_r <= out_x_r + XW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                S_FILL: begin
                    if (accept_s && in_x_r == {XW{1'b0}} && in_y_r == YW'(1)) begin
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept_s && in_x_r == X_LAST && in_y_r == Y_LAST) begin
                        state_r <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (load_s && last_s) begin
                        state_r <= S_FILL;
                    end
                end
                default: state_r <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dilation_stream.sv
// Directed bench for dilation_stream at 5x4 frames with hand-computed expected outputs.
module tb_dilation_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] fin  [40];
    logic [7:0] fexp [40];

    always #5 clk = ~clk;

    dilation_stream #(.WIDTH(5), .HEIGHT(4), .THRESH(127)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_frames();
        for (int i = 0; i < 40; i++) begin
            fin[i]  = 8'd0;
            fexp[i] = 8'd0;
        end
    endtask

    // Frame with single 200 at (2,1) placed at offset base.
    task automatic frame_dot(input int base);
        fin[base + 7]   = 8'd200;
        fexp[base + 6]  = 8'd200;
        fexp[base + 8]  = 8'd200;
        fexp[base + 11] = 8'd200;
        fexp[base + 12] = 8'd200;
        fexp[base + 13] = 8'd200;
    endtask

    // Frame with centre 126 at (2,1), neighbours 128 at (1,0) and 250 at (3,2).
    task automatic frame_mix(input int base);
        fin[base + 7]   = 8'd126;
        fin[base + 1]   = 8'd128;
        fin[base + 13]  = 8'd250;
        fexp[base + 6]  = 8'd128;
        fexp[base + 7]  = 8'd250;
        fexp[base + 8]  = 8'd250;
        fexp[base + 12] = 8'd250;
    endtask

    task automatic run_stream(input string name, input int nin, input int nout,
                              input int ss, input int sl, input int exp_low);
        int ii, oi, cyc, low, lasts, first_acc;
        logic       snap_v, snap_l;
        logic [7:0] snap_p;
        ii = 0; oi = 0; cyc = 0; low = 0; lasts = 0; first_acc = -1;
        snap_v = 1'b0; snap_l = 1'b0; snap_p = 8'd0;
        while (oi < nout && cyc < 400) begin
            @(negedge clk);
            out_ready = !(cyc >= ss && cyc < ss + sl);
            in_valid  = (ii < nin);
            in_pixel  = (ii < nin) ? fin[ii] : 8'd0;
            #1;
            if (out_valid && first_acc < 0) first_acc = ii;
            if (cyc == ss && sl > 0) begin
                snap_v = out_valid; snap_p = out_pixel; snap_l = out_last;
                chk($sformatf("%s stall_valid", name), {31'd0, out_valid}, 32'd1);
            end
            if (cyc >= ss && cyc < ss + sl) begin
                chk($sformatf("%s stall_in_ready c%0d", name, cyc), {31'd0, in_ready}, 32'd0);
                if (cyc > ss) begin
                    chk($sformatf("%s stall_hold c%0d", name, cyc),
                        {22'd0, out_valid, out_last, out_pixel}, {22'd0, snap_v, snap_l, snap_p});
                end
            end
            if (in_valid && !in_ready) low++;
            if (in_valid && in_ready) ii++;
            if (out_valid && out_ready) begin
                chk($sformatf("%s pix%0d", name, oi), {24'd0, out_pixel}, {24'd0, fexp[oi]});
                chk($sformatf("%s last%0d", name, oi), {31'd0, out_last}, {31'd0, (oi % 20) == 19});
                if (out_last) lasts++;
                oi++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("%s out_count", name), oi, nout);
        chk($sformatf("%s in_count", name), ii, nin);
        chk($sformatf("%s first_valid_accepts", name), first_acc, 32'd7);
        chk($sformatf("%s in_ready_low", name), low, exp_low);
        chk($sformatf("%s last_count", name), lasts, nout / 20);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_pixel", {24'd0, out_pixel}, 32'd0);
        chk("reset out_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);

        // 1: all-zero frame
        clear_frames();
        run_stream("zero", 20, 20, 1000, 0, 0);

        // 2: single bright pixel
        clear_frames();
        frame_dot(0);
        run_stream("dot", 20, 20, 1000, 0, 0);

        // 3a: centre equal to threshold surrounded by 255 -> all zero
        clear_frames();
        for (int y = 1; y < 4; y++)
            for (int x = 1; x < 4; x++)
                fin[y * 5 + x] = 8'd255;
        fin[12] = 8'd127;
        run_stream("thresh", 20, 20, 1000, 0, 0);

        // 3b: centre 126 with 128 and 250 neighbours
        clear_frames();
        frame_mix(0);
        run_stream("mix", 20, 20, 1000, 0, 0);

        // 4: downstream stall for 10 cycles mid-RUN
        clear_frames();
        frame_dot(0);
        run_stream("stall", 20, 20, 10, 10, 10);

        // 5: reset after 9 accepts, then a clean frame
        clear_frames();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'd77;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset out_pixel", {24'd0, out_pixel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_dot(0);
        run_stream("post_reset", 20, 20, 1000, 0, 0);

        // 6: two back-to-back frames
        clear_frames();
        frame_dot(0);
        frame_mix(20);
        run_stream("b2b", 40, 40, 1000, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
